fb_arbiter: RTL
===============

Name: fb_arbiter

Overview:
- Shares the single-port synchronous frame-buffer RAM between two requesters: the VGA scan-out prefetcher and the CPU data port (image ops: xor, not, add, init).
- VGA has fixed priority so that the display never tears.
- A streak counter guarantees the CPU one slot after every VGA_BURST consecutive VGA grants while the CPU is waiting.
- Sits between CPU, VGA controller and the frame-buffer RAM inside the CPU_VGA top level.

Parameters:
- ADDR_W, 17, frame-buffer address width (320x240 pixels).
- DATA_W, 8, pixel width.
- VGA_BURST, 4, maximum consecutive VGA grants while a CPU request is pending; legal values are 1..15.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- vga_req  in  1  VGA read request; held until granted.
- vga_addr  in  ADDR_W  VGA read address.
- vga_gnt  out  1  combinational; request accepted on this edge.
- vga_valid  out  1  one-cycle pulse; vga_data is valid.
- vga_data  out  DATA_W  read data for VGA.
- cpu_req  in  1  CPU request; held with its fields until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  CPU read data; held until the next CPU read completes.
- mem_addr  out  ADDR_W  registered RAM address.
- mem_we  out  1  registered RAM write enable.
- mem_wdata  out  DATA_W  registered RAM write data.
- mem_rdata  in  DATA_W  RAM read data; valid the cycle after the RAM samples the address.

Behaviour:
- Reset (reset=0) forces:
  - every output register to 0: mem_addr, mem_we, mem_wdata, vga_valid, vga_data, cpu_ack, cpu_rdata;
  - the streak counter to 0;
  - the CPU FSM to C_IDLE.
- Reset asserted mid-operation drops any in-flight read: no vga_valid and no cpu_ack are produced for it.
- CPU FSM states: C_IDLE, C_RD1, C_RD2, C_ACK.
- Arbitration is evaluated every edge. cpu_pend = cpu_req && state==C_IDLE.
  - cpu_win = cpu_pend && (!vga_req || streak==VGA_BURST).
  - vga_gnt = vga_req && !cpu_win.
- Issue on edge N:
  - The winner's address is registered into mem_addr.
  - mem_we = cpu_win && cpu_we; mem_wdata = cpu_wdata.
  - If nothing is granted, mem_we=0 and mem_addr holds its previous value.
- VGA read pipeline: a grant at edge N gives vga_valid=1 with vga_data=mem_rdata in the cycle after edge N+2. The pipeline is fully pipelined: one VGA grant per cycle, back-to-back.
- CPU write:
  - C_IDLE -> C_ACK at the issue edge N.
  - cpu_ack=1 in the cycle after N+1.
  - C_ACK -> C_IDLE on the next edge.
- CPU read:
  - C_IDLE -> C_RD1 (edge N) -> C_RD2 (edge N+1) -> C_ACK (edge N+2).
  - cpu_rdata is captured at edge N+2; cpu_ack=1 in that following cycle.
  - Then C_ACK -> C_IDLE.
- Only one CPU transaction is outstanding at a time. cpu_req is ignored outside C_IDLE, and on the edge that ends C_ACK.
  - The CPU drops or changes cpu_req during the ack cycle.
  - A request still high after C_IDLE is re-entered counts as a new request.
- Streak counter:
  - Increments on each VGA grant while cpu_pend=1, saturating at VGA_BURST.
  - Clears on a CPU grant, or on any edge where cpu_pend=0.
- Read-data routing: a 2-deep source tag shift register (VGA/CPU/none) tracks each issue slot, so returning data is steered to the correct requester.
- No write-through forwarding: a VGA read of an address written in the same slot pair returns RAM behaviour (old data).

Test Plan:
- Reset held low with requests active -> all outputs 0; after release, idle cycles give no mem_we, no valid, no ack.
- CPU write addr=0x00010, data=0xA5 with vga_req=0 -> mem_we=1, mem_addr=0x00010 and mem_wdata=0xA5 in the cycle after the grant; cpu_ack pulses exactly once, two cycles after request sampled.
- CPU read of 0x00010 (RAM model returns 0xA5) -> cpu_ack three cycles after grant; cpu_rdata=0xA5; vga_valid stays 0.
- vga_req held high for 12 cycles with incrementing addresses, cpu_req read high from cycle 0 -> vga_gnt pattern 1,1,1,1,0,1,...; the CPU granted exactly at slot 5; every vga_valid carries data matching its own address; 11 vga_valid pulses plus 1 cpu_ack.
- Simultaneous first requests with streak=0 -> VGA granted first; vga_gnt=1 and cpu_ack delayed.
- reset pulsed low one cycle after a CPU read grant -> no cpu_ack; FSM in C_IDLE; the next cpu_req completes normally.

Source files
------------

// File: rtl/fb_arbiter.sv
// fb_arbiter
// Shares one single-port synchronous frame-buffer RAM between the VGA
// scan-out prefetcher and the CPU data port. VGA has fixed priority, but a
// streak counter forces one CPU slot after VGA_BURST back-to-back VGA
// grants while the CPU is waiting, so the CPU can never starve.
//
// Ports
//   clk, reset            : rising-edge clock, asynchronous active-low reset
//   vga_req/vga_addr      : VGA read request, held until vga_gnt
//   vga_gnt               : combinational grant, request taken on this edge
//   vga_valid/vga_data    : one-cycle read-data pulse for VGA
//   cpu_req/we/addr/wdata : CPU request, fields held until cpu_ack
//   cpu_ack               : one-cycle completion pulse
//   cpu_rdata             : last CPU read data, held until the next read
//   mem_addr/we/wdata     : registered RAM command
//   mem_rdata             : RAM read data, one cycle after address sampled
module fb_arbiter #(
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 8,
  parameter int VGA_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_valid,
  output logic [DATA_W-1:0] vga_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_RD1  = 2'd1;
  localparam logic [1:0] C_RD2  = 2'd2;
  localparam logic [1:0] C_ACK  = 2'd3;

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_VGA  = 2'd1;
  localparam logic [1:0] TAG_CPU  = 2'd2;

  localparam logic [3:0] BURST = 4'(VGA_BURST);

  logic [1:0] state;
  logic [3:0] streak;
  logic [1:0] tag0;
  logic [1:0] tag1;
  logic       cpu_pend;
  logic       cpu_win;

  // The CPU only competes while its FSM is idle; it beats VGA when VGA is
  // quiet or when VGA has used up its allowed streak.
  assign cpu_pend = cpu_req && (state == C_IDLE);
  assign cpu_win  = cpu_pend && (!vga_req || (streak == BURST));
  assign vga_gnt  = vga_req && !cpu_win;

  // RAM command register: the winner's address is launched on the issue
  // edge; with no winner the address is held and no write happens.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      mem_we <= cpu_win && cpu_we;
      if (cpu_win) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end else if (vga_gnt) begin
        mem_addr <= vga_addr;
      end
    end
  end

  // Streak counter: counts VGA wins while the CPU is kept waiting and
  // resets whenever the CPU wins or is not waiting at all.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak <= '0;
    end else if (cpu_win || !cpu_pend) begin
      streak <= '0;
    end else if (vga_gnt && (streak != BURST)) begin
      streak <= streak + 4'd1;
    end
  end

  // Two-deep source tag pipeline: tag1 names the requester whose read data
  // is on mem_rdata during the current cycle. CPU writes return nothing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag0 <= TAG_NONE;
      tag1 <= TAG_NONE;
    end else begin
      if (cpu_win)
        tag0 <= cpu_we ? TAG_NONE : TAG_CPU;
      else if (vga_gnt)
        tag0 <= TAG_VGA;
      else
        tag0 <= TAG_NONE;
      tag1 <= tag0;
    end
  end

  // Steer returning read data to its owner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vga_valid <= 1'b0;
      vga_data  <= '0;
      cpu_rdata <= '0;
    end else begin
      vga_valid <= (tag1 == TAG_VGA);
      if (tag1 == TAG_VGA)
        vga_data <= mem_rdata;
      if (tag1 == TAG_CPU)
        cpu_rdata <= mem_rdata;
    end
  end

  // CPU FSM and ack. A read pulses ack as it enters C_ACK (data captured on
  // the same edge). A write enters C_ACK on its issue edge and pulses ack
  // on leaving it; the !cpu_ack term stops a read's C_ACK exit edge from
  // producing a second pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= C_IDLE;
      cpu_ack <= 1'b0;
    end else begin
      cpu_ack <= (state == C_RD2) || ((state == C_ACK) && !cpu_ack);
      case (state)
        C_IDLE:  if (cpu_win) state <= cpu_we ? C_ACK : C_RD1;
        C_RD1:   state <= C_RD2;
        C_RD2:   state <= C_ACK;
        default: state <= C_IDLE;
      endcase
    end
  end

endmodule
